// File: rtl/detector_pkg.sv
// -----------------------------------------------------------------------------
// detector_pkg
// Shared definitions for the detector front-end timing block:
//   - FSM state encoding (also the sts_state read-back value)
//   - control register bit positions (ctrl register of the Avalon-MM bank)
//   - status register bit layout (busy, state, overrun)
// No ports; imported by detector_timing_gen.
// -----------------------------------------------------------------------------
package detector_pkg;

  // FSM state encoding, visible to software through sts_state
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_INTEG = 2'd1;
  localparam logic [1:0] ST_READ  = 2'd2;
  localparam logic [1:0] ST_GAP   = 2'd3;

  // Control register bit positions
  localparam int CTRL_EN    = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_START = 2;

  // Status register bit layout
  localparam int STS_BUSY      = 0;
  localparam int STS_STATE_LSB = 1;
  localparam int STS_STATE_MSB = 2;
  localparam int STS_OVERRUN   = 3;

endpackage

// File: rtl/det_period_counter.sv
// -----------------------------------------------------------------------------
// det_period_counter
// Loadable down-counter used for the integration/gap, pixel and line counts.
// load has priority over en; the count holds at zero. tc flags count == 0,
// so a counter loaded with N-1 spends N cycles before tc is seen.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   load         load load_value this cycle
//   en           decrement this cycle (ignored while load is high)
//   load_value   value to load
//   count        current count
//   tc           terminal count (count == 0)
// -----------------------------------------------------------------------------
module det_period_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (en && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/detector_timing_gen.sv
// -----------------------------------------------------------------------------
// detector_timing_gen
// Frame/line timing sequencer for the detector front end. Timing fields come
// from the register bank and are captured when a frame enters INTEG, so CPU
// writes mid-frame only affect the next frame.
//
// Optional build macro: DET_EXT_TRIG_EN adds an ext_trig input whose rising
// edge (after a 2-FF synchroniser) acts like a cfg_start rising edge.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   ext_trig          external trigger (only with DET_EXT_TRIG_EN)
//   cfg_enable        block enable; low aborts any frame and clears overrun
//   cfg_continuous    1 = free-running frames, 0 = one frame per start
//   cfg_start         start request, rising edge only
//   cfg_int_time      integration clocks (0 treated as 1)
//   cfg_line_len      active readout clocks per line (0 treated as 1)
//   cfg_hblank        idle clocks after each line (0 allowed)
//   cfg_num_lines     lines per frame (0 treated as 1)
//   cfg_frame_gap     idle clocks after the last line (0 allowed)
//   det_int           integration window
//   det_fsync         frame start pulse (first integration cycle)
//   det_lsync         line start pulse (first rd_valid cycle of a line)
//   det_rd_valid      readout pixel window
//   sts_busy          state != IDLE
//   sts_state         FSM state (IDLE=0, INTEG=1, READ=2, GAP=3)
//   sts_frame_cnt     completed frames, wrapping
//   sts_overrun       sticky: start request seen while busy
// All outputs are registered.
// -----------------------------------------------------------------------------
module detector_timing_gen
  import detector_pkg::*;
#(
  parameter int CNT_WIDTH  = 32,
  parameter int LINE_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
`ifdef DET_EXT_TRIG_EN
  input  logic                  ext_trig,
`endif
  input  logic                  cfg_enable,
  input  logic                  cfg_continuous,
  input  logic                  cfg_start,
  input  logic [CNT_WIDTH-1:0]  cfg_int_time,
  input  logic [LINE_WIDTH-1:0] cfg_line_len,
  input  logic [LINE_WIDTH-1:0] cfg_hblank,
  input  logic [LINE_WIDTH-1:0] cfg_num_lines,
  input  logic [CNT_WIDTH-1:0]  cfg_frame_gap,
  output logic                  det_int,
  output logic                  det_fsync,
  output logic                  det_lsync,
  output logic                  det_rd_valid,
  output logic                  sts_busy,
  output logic [1:0]            sts_state,
  output logic [31:0]           sts_frame_cnt,
  output logic                  sts_overrun
);

  // max(v,1)-1: reload value giving max(v,1) cycles until terminal count
  function automatic logic [CNT_WIDTH-1:0] m1_cnt(input logic [CNT_WIDTH-1:0] v);
    return (v == '0) ? '0 : v - CNT_WIDTH'(1);
  endfunction

  function automatic logic [LINE_WIDTH-1:0] m1_line(input logic [LINE_WIDTH-1:0] v);
    return (v == '0) ? '0 : v - LINE_WIDTH'(1);
  endfunction

  // ---------------------------------------------------------------------------
  // Start edge detection (plus optional synchronised external trigger)
  // ---------------------------------------------------------------------------
  logic cfg_start_d;
  logic trig_edge;
  logic start_edge;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cfg_start_d <= 1'b0;
    else        cfg_start_d <= cfg_start;
  end

`ifdef DET_EXT_TRIG_EN
  // [0],[1]: synchroniser; [2]: previous synchronised value for edge detect
  logic [2:0] trig_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) trig_sync <= '0;
    else        trig_sync <= {trig_sync[1:0], ext_trig};
  end

  assign trig_edge = trig_sync[1] & ~trig_sync[2];
`else
  assign trig_edge = 1'b0;
`endif

  assign start_edge = (cfg_start & ~cfg_start_d) | trig_edge;

  // ---------------------------------------------------------------------------
  // Counters: t = integration/gap, p = pixels or hblank in a line, l = lines
  // ---------------------------------------------------------------------------
  logic                  t_load, t_en, t_tc;
  logic [CNT_WIDTH-1:0]  t_val, t_count;
  logic                  p_load, p_en, p_tc;
  logic [LINE_WIDTH-1:0] p_val, p_count;
  logic                  l_load, l_en, l_tc;
  logic [LINE_WIDTH-1:0] l_val, l_count;

  det_period_counter #(.WIDTH(CNT_WIDTH)) u_t_cnt (
    .clk(clk), .rst_n(rst_n), .load(t_load), .en(t_en),
    .load_value(t_val), .count(t_count), .tc(t_tc)
  );

  det_period_counter #(.WIDTH(LINE_WIDTH)) u_p_cnt (
    .clk(clk), .rst_n(rst_n), .load(p_load), .en(p_en),
    .load_value(p_val), .count(p_count), .tc(p_tc)
  );

  det_period_counter #(.WIDTH(LINE_WIDTH)) u_l_cnt (
    .clk(clk), .rst_n(rst_n), .load(l_load), .en(l_en),
    .load_value(l_val), .count(l_count), .tc(l_tc)
  );

  // Counter values themselves are not needed here beyond tc
  logic unused_counts;
  assign unused_counts = ^{t_count, p_count, l_count};

  // ---------------------------------------------------------------------------
  // Configuration shadows. The integration counter is loaded straight from
  // cfg_int_time at INTEG entry, so it is its own shadow.
  // ---------------------------------------------------------------------------
  logic [LINE_WIDTH-1:0] sh_line_len, sh_hblank, sh_num_lines;
  logic [CNT_WIDTH-1:0]  sh_frame_gap;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  logic [1:0] state, state_next;
  logic       rd_blank, rd_blank_next;   // READ sub-phase: 1 = in hblank
  logic       enter_integ;
  logic       line_start;
  logic       frame_done;
  logic       frame_exit;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      rd_blank <= 1'b0;
    end else begin
      state    <= state_next;
      rd_blank <= rd_blank_next;
    end
  end

  // Next-state and counter control
  always_comb begin
    state_next    = state;
    rd_blank_next = rd_blank;
    t_load = 1'b0; t_en = 1'b0; t_val = '0;
    p_load = 1'b0; p_en = 1'b0; p_val = '0;
    l_load = 1'b0; l_en = 1'b0; l_val = '0;
    enter_integ = 1'b0;
    line_start  = 1'b0;
    frame_done  = 1'b0;
    frame_exit  = 1'b0;

    if (!cfg_enable) begin
      state_next    = ST_IDLE;
      rd_blank_next = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_edge) enter_integ = 1'b1;
        end
        ST_INTEG: begin
          if (t_tc) begin
            state_next    = ST_READ;
            rd_blank_next = 1'b0;
            p_load        = 1'b1;
            p_val         = m1_line(sh_line_len);
            l_load        = 1'b1;
            l_val         = m1_line(sh_num_lines);
            line_start    = 1'b1;
          end else begin
            t_en = 1'b1;
          end
        end
        ST_READ: begin
          if (!p_tc) begin
            p_en = 1'b1;
          end else if (!rd_blank && (sh_hblank != '0)) begin
            // active part done, hblank follows
            rd_blank_next = 1'b1;
            p_load        = 1'b1;
            p_val         = sh_hblank - LINE_WIDTH'(1);
          end else if (!l_tc) begin
            // line (including any hblank) done, more lines to go
            rd_blank_next = 1'b0;
            p_load        = 1'b1;
            p_val         = m1_line(sh_line_len);
            l_en          = 1'b1;
            line_start    = 1'b1;
          end else begin
            // last line done: frame counts as complete here
            frame_done    = 1'b1;
            rd_blank_next = 1'b0;
            if (sh_frame_gap != '0) begin
              state_next = ST_GAP;
              t_load     = 1'b1;
              t_val      = sh_frame_gap - CNT_WIDTH'(1);
            end else begin
              frame_exit = 1'b1;
            end
          end
        end
        ST_GAP: begin
          if (t_tc) frame_exit = 1'b1;
          else      t_en       = 1'b1;
        end
      endcase

      // A zero gap exits straight from READ so back-to-back frames abut
      if (frame_exit) begin
        if (cfg_continuous) enter_integ = 1'b1;
        else                state_next  = ST_IDLE;
      end

      if (enter_integ) begin
        state_next = ST_INTEG;
        t_load     = 1'b1;
        t_val      = m1_cnt(cfg_int_time);
      end
    end
  end

  // Output decode from the upcoming state, registered below
  logic        det_int_n, det_fsync_n, det_lsync_n, det_rd_valid_n, sts_busy_n;
  logic        sts_overrun_n;
  logic [31:0] sts_frame_cnt_n;

  always_comb begin
    det_int_n       = (state_next == ST_INTEG);
    det_fsync_n     = enter_integ;
    det_lsync_n     = line_start;
    det_rd_valid_n  = (state_next == ST_READ) && !rd_blank_next;
    sts_busy_n      = (state_next != ST_IDLE);
    sts_frame_cnt_n = frame_done ? (sts_frame_cnt + 32'd1) : sts_frame_cnt;
    // disable clears overrun even if a start edge arrives in the same cycle
    if (!cfg_enable)                             sts_overrun_n = 1'b0;
    else if (start_edge && (state != ST_IDLE))   sts_overrun_n = 1'b1;
    else                                         sts_overrun_n = sts_overrun;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      det_int       <= 1'b0;
      det_fsync     <= 1'b0;
      det_lsync     <= 1'b0;
      det_rd_valid  <= 1'b0;
      sts_busy      <= 1'b0;
      sts_frame_cnt <= '0;
      sts_overrun   <= 1'b0;
    end else begin
      det_int       <= det_int_n;
      det_fsync     <= det_fsync_n;
      det_lsync     <= det_lsync_n;
      det_rd_valid  <= det_rd_valid_n;
      sts_busy      <= sts_busy_n;
      sts_frame_cnt <= sts_frame_cnt_n;
      sts_overrun   <= sts_overrun_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_line_len  <= '0;
      sh_hblank    <= '0;
      sh_num_lines <= '0;
      sh_frame_gap <= '0;
    end else if (enter_integ) begin
      sh_line_len  <= cfg_line_len;
      sh_hblank    <= cfg_hblank;
      sh_num_lines <= cfg_num_lines;
      sh_frame_gap <= cfg_frame_gap;
    end
  end

  assign sts_state = state;

endmodule
